inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the immediate generator: packs register fields, funct3 and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Handles I-ALU, I-load, S and B formats.
- Sits in the test/boot instruction-stream path and feeds the instruction memory writer.
- Valid/ready on both sides, with a small registered output FIFO.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the encoded-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- in_fmt  in  2  format code: 0=I_ALU, 1=I_LOAD, 2=S, 3=B
- in_rd  in  5  destination register (I formats only)
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (S/B only)
- in_funct3  in  3  funct3 field
- in_imm  in  32  signed byte-offset/immediate
- out_valid  out  1  inst_code valid
- out_ready  in  1  consumer accepts
- inst_code  out  32  encoded instruction
- out_err  out  1  immediate not representable (see Optional Feature)
- enc_count  out  CNT_W  instructions accepted since reset

Behaviour:
- Reset (reset=0, async): FIFO empty, out_valid=0, inst_code=0, out_err=0, enc_count=0, in_ready=1 on the first edge after release.
- Accept when in_valid&&in_ready. Encoding is combinational into the FIFO write port; the word is visible at the head at most one cycle after acceptance.
  - Empty FIFO: out_valid=1 the cycle after acceptance (latency 1).
- Pop when out_valid&&out_ready. inst_code/out_err are taken from the FIFO head.
  - out_valid=!empty.
  - Head stays stable while out_valid&&!out_ready.
- in_ready=!full. Registered, no combinational path from out_ready.
  - Full FIFO with simultaneous pop: still no push that cycle.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- enc_count increments per accept and wraps to 0 at 2^CNT_W.
- Opcodes: I_ALU=0010011, I_LOAD=0000011, S=0100011, B=1100011.
- I formats: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode. rs2 is ignored.
- S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]. rd is ignored.
- B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11]. imm[0] is dropped.
- Immediate bits above the field width are truncated silently.
- Reset asserted mid-transfer: queued words are discarded and enc_count clears.

Optional Feature:
- Macro INST_ENCODER_RANGE_CHECK_EN.
- When defined, out_err is stored per entry:
  - I/S: error unless in_imm[31:11] are all equal.
  - B: error unless in_imm[31:12] are all equal and in_imm[0]=0.
  - The word is still encoded (truncated) and delivered with out_err=1.
- When undefined: out_err tied 0, no range logic is synthesised, and the FIFO is 32 bits wide.

Decomposition:
- Package inst_enc_pkg:
  - fmt_e enum (I_ALU, I_LOAD, S, B)
  - 7-bit opcode localparams
  - entry struct {inst[31:0], err}
- One natural sub-module, inst_enc_fifo: a parameterised synchronous FIFO with async active-low reset.
- The encoder is a combinational function of the request plus the FIFO.

Test Plan:
- I_ALU, rd=5, rs1=6, funct3=0, imm=0xFFFFFFFF -> inst_code=0xFFF30293, out_err=0, out_valid one cycle after accept.
- I_LOAD, rd=1, rs1=2, funct3=2, imm=8 -> 0x00812083. Then S, rs1=4, rs2=3, funct3=2, imm=12 -> 0x00322623. Order preserved, enc_count=2.
- B, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFF8 -> 0xFE208CE3.
- out_ready=0, push 3 back-to-back -> in_ready falls after 2 accepts and the third is held. Raise out_ready -> 3 words out in order, enc_count=3.
- With macro defined: I_ALU imm=0x800 -> inst_code[31:20]=0x800, out_err=1. B imm=0x5 -> out_err=1. Without macro -> out_err=0.
- Fill FIFO, assert reset for 1 cycle mid-stream -> out_valid=0, enc_count=0 immediately (async); after release, in_ready=1.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared types and opcode constants for the RV32I instruction encoder.
// Used by inst_encoder and its output FIFO.
package inst_enc_pkg;

  typedef enum logic [1:0] {
    I_ALU  = 2'd0,
    I_LOAD = 2'd1,
    S      = 2'd2,
    B      = 2'd3
  } fmt_e;

  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

endpackage

// File: rtl/inst_enc_fifo.sv
// Small synchronous FIFO with async active-low reset. in/out flags are registered
// or derived from registered occupancy only; the head word reads as 0 when empty.
module inst_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_not_full,
  input  logic             i_pop,
  output logic             o_not_empty,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_not_full;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  assign w_push       = i_push && r_not_full;
  assign w_pop        = i_pop && (r_count != '0);
  assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // r_not_full stays low during reset so the first accept comes after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_not_full <= (w_count_next != (AW + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_not_full  = r_not_full;
  assign o_not_empty = (r_count != '0);
  assign o_data      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_encoder.sv
// Packs rd/rs1/rs2/funct3/immediate into RV32I I-ALU, I-load, S and B words.
// Define INST_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their field.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_code,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  logic [31:0]      w_inst;
  logic             w_accept;
  logic [CNT_W-1:0] r_enc_count;

  always_comb begin
    w_inst = '0;
    case (in_fmt)
      I_ALU:   w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I_ALU};
      I_LOAD:  w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I_LOAD};
      S:       w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_S};
      B:       w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], OPC_B};
      default: w_inst = '0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_enc_count <= '0;
    else if (w_accept) r_enc_count <= r_enc_count + 1'b1;
  end

  assign enc_count = r_enc_count;

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic   w_err;
  entry_t w_wr_entry;
  entry_t w_head;

  // Representable iff all bits above the field's sign bit replicate it
  always_comb begin
    if (in_fmt == B)
      w_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
    else
      w_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
  end

  assign w_wr_entry = '{inst: w_inst, err: w_err};

  inst_enc_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (in_valid),
    .i_data      (w_wr_entry),
    .o_not_full  (in_ready),
    .i_pop       (out_ready),
    .o_not_empty (out_valid),
    .o_data      (w_head)
  );

  assign inst_code = w_head.inst;
  assign out_err   = w_head.err;
`else
  logic w_unused_imm;
  assign w_unused_imm = ^in_imm[31:13];

  inst_enc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (in_valid),
    .i_data      (w_inst),
    .o_not_full  (in_ready),
    .i_pop       (out_ready),
    .o_not_empty (out_valid),
    .o_data      (inst_code)
  );

  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed plus randomized bench for inst_encoder, scored against a queue model
// that builds words from the instruction-format bit layouts.
module tb_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_fmt = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      inst_code;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_inst[$];
  bit          q_err[$];
  int          exp_count = 0;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst_code (inst_code),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int fmt, input int rd, input int rs1,
                                           input int rs2, input int f3, input logic [31:0] imm);
    int unsigned u;
    int unsigned w;
    u = imm;
    case (fmt)
      0, 1: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
                | ((fmt == 0) ? 32'h13 : 32'h03);
      2:    w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
      default: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                | (((u >> 11) & 1) << 7) | 32'h63;
    endcase
    return w;
  endfunction

  function automatic bit ref_err(input int fmt, input logic [31:0] imm);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    if (fmt == 3) return (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
    return (s < -2048) || (s > 2047);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input int fmt, input int rd, input int rs1, input int rs2,
                         input int f3, input logic [31:0] imm);
    in_fmt    = 2'(fmt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    if ($urandom_range(0, 2) == 0) imm = $urandom;
    else imm = 32'($urandom_range(0, 8191)) - 32'd4096;
    set_req($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 7), imm);
  endtask

  // One clock: score handshakes seen before the edge, then check state after it
  task automatic tick();
    bit push;
    bit pop;
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    if (pop) begin
      if (q_inst.size() == 0) chk("pop_when_model_empty", 32'(out_valid), 32'd0);
      else begin
        chk("pop_inst", inst_code, q_inst.pop_front());
        chk("pop_err", 32'(out_err), 32'(q_err.pop_front()));
      end
    end
    if (push) begin
      q_inst.push_back(ref_word(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2),
                                int'(in_funct3), in_imm));
      q_err.push_back(ref_err(int'(in_fmt), in_imm));
      exp_count = (exp_count + 1) % (1 << CNT_W);
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(q_inst.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q_inst.size() < DEPTH));
    chk("enc_count", 32'(enc_count), 32'(exp_count));
    if (q_inst.size() != 0) begin
      chk("head_inst", inst_code, q_inst[0]);
      chk("head_err", 32'(out_err), 32'(q_err[0]));
    end
    $display("cycle: push=%0d pop=%0d occ=%0d count=%0d", push, pop, q_inst.size(), exp_count);
  endtask

  initial begin
    bit acc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst_code", inst_code, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // I_ALU, all-ones immediate
    out_ready = 1'b1;
    set_req(0, 5, 6, 0, 0, 32'hFFFFFFFF);
    tick();
    in_valid = 1'b0;
    chk("ialu_word", inst_code, 32'hFFF30293);
    chk("ialu_lat1", 32'(out_valid), 32'd1);
    tick();

    // I_LOAD then S, order preserved
    out_ready = 1'b0;
    set_req(1, 1, 2, 0, 2, 32'd8);
    tick();
    set_req(2, 0, 4, 3, 2, 32'd12);
    tick();
    in_valid = 1'b0;
    chk("iload_word", inst_code, 32'h00812083);
    out_ready = 1'b1;
    tick();
    chk("s_word", inst_code, 32'h00322623);
    tick();

    // B, negative offset
    set_req(3, 0, 1, 2, 0, 32'hFFFFFFF8);
    tick();
    in_valid = 1'b0;
    chk("b_word", inst_code, 32'hFE208CE3);
    tick();

    // Back-pressure: third request held until space appears
    out_ready = 1'b0;
    set_req(0, 3, 4, 0, 1, 32'd100);
    tick();
    set_req(1, 7, 8, 0, 4, 32'hFFFFF800);
    tick();
    set_req(2, 0, 9, 10, 0, 32'd2047);
    tick();
    chk("bp_held", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end

    // Range boundaries
    set_req(0, 1, 1, 0, 0, 32'h00000800);
    tick();
    set_req(3, 0, 1, 1, 0, 32'h00000005);
    tick();
    set_req(3, 0, 2, 3, 1, 32'hFFFFF000);
    tick();
    set_req(2, 0, 5, 6, 2, 32'hFFFFF7FF);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Randomized traffic with a source that holds stalled requests
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        if ($urandom_range(0, 3) != 0) rand_req();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset in the middle of a full queue
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      tick();
    end
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc_count", 32'(enc_count), 32'd0);
    chk("mid_rst_inst_code", inst_code, 32'd0);
    q_inst.delete();
    q_err.delete();
    exp_count = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(in_valid && !in_ready)) rand_req();
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
